switch_debounce_irq_ctrl: RTL



---
 rtl/switch_debounce_irq_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/switch_debounce_irq_ctrl.sv
// Avalon-MM switch controller: per-bit two-flop synchroniser, counter debounce,
// selectable edge capture with write-one-to-clear, and a masked level interrupt.
module switch_debounce_irq_ctrl #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE = 2'd2;
    localparam logic [1:0] ADDR_CONFIG  = 2'd3;

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0]            deb_q, deb_d;
    logic [WIDTH-1:0]            deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]            edge_capture_q, edge_capture_d;
    logic [1:0]                  edge_sel_q, edge_sel_d;
    logic [31:0]                 readdata_q, readdata_d;
    logic                        irq_q, irq_d;

    logic                        wr_en;
    logic [WIDTH-1:0]            rise, fall, ev, clr;
    logic                        unused_wdata;

    // Only the low WIDTH bits of writedata reach any register.
    assign unused_wdata = ^writedata;

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        sync1_d        = in_port;
        sync2_d        = sync1_q;
        deb_d          = deb_q;
        cnt_d          = cnt_q;
        deb_dly_d      = deb_q;
        irq_mask_d     = irq_mask_q;
        edge_sel_d     = edge_sel_q;
        readdata_d     = '0;
        clr            = '0;
        wr_en          = chipselect & ~write_n;

        // A sample equal to the accepted level restarts the stability count.
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        rise = deb_q & ~deb_dly_q;
        fall = ~deb_q & deb_dly_q;
        ev   = ({WIDTH{edge_sel_q[0]}} & rise) | ({WIDTH{edge_sel_q[1]}} & fall);

        if (wr_en) begin
            case (address)
                ADDR_MASK:    irq_mask_d = writedata[WIDTH-1:0];
                ADDR_CAPTURE: clr        = writedata[WIDTH-1:0];
                ADDR_CONFIG:  edge_sel_d = writedata[1:0];
                default:      ;
            endcase
        end

        // A new event outranks a simultaneous clear of the same bit.
        edge_capture_d = (edge_capture_q & ~clr) | ev;

        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = deb_q;
            ADDR_MASK:    readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_CAPTURE: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:      readdata_d[1:0]       = edge_sel_q;
        endcase

        irq_d = |(edge_capture_q & irq_mask_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            deb_q          <= '0;
            deb_dly_q      <= '0;
            cnt_q          <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            edge_sel_q     <= 2'b11;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            deb_q          <= deb_d;
            deb_dly_q      <= deb_dly_d;
            cnt_q          <= cnt_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            edge_sel_q     <= edge_sel_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
